// File: rtl/pulse_det_pkg.sv
// pulse_det_pkg: shared types and constants for the pulse event detector.
// Holds the FSM state enum, ev_flags bit indices and default widths.
package pulse_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_HOLDOFF
   } state_t;

   localparam int FLG_TRUNC  = 0;
   localparam int FLG_PILEUP = 1;
   localparam int FLG_SUMSAT = 2;

   localparam int DEF_DATA_W    = 14;
   localparam int DEF_TS_W      = 32;
   localparam int DEF_SUM_W     = 24;
   localparam int DEF_WID_W     = 12;
   localparam int DEF_MIN_WIDTH = 2;
   localparam int DEF_MAX_WIDTH = 1024;
   localparam int DEF_HOLDOFF   = 8;
   localparam int DROP_W        = 16;

endpackage

// File: rtl/pulse_event_slot.sv
// pulse_event_slot: single-entry valid/ready holding register for pulse events.
// Ports: clk, rst (sync, high); i_emit + i_* new event; i_ready downstream
//        accept; o_valid + o_* held event; o_drop_cnt saturating lost-event count.
module pulse_event_slot
   import pulse_det_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int SUM_W  = DEF_SUM_W,
   parameter int WID_W  = DEF_WID_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_emit,
   input  logic signed [DATA_W-1:0] i_peak,
   input  logic [WID_W-1:0]         i_width,
   input  logic [SUM_W-1:0]         i_sum,
   input  logic [TS_W-1:0]          i_ts,
   input  logic [2:0]               i_flags,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic signed [DATA_W-1:0] o_peak,
   output logic [WID_W-1:0]         o_width,
   output logic [SUM_W-1:0]         o_sum,
   output logic [TS_W-1:0]          o_ts,
   output logic [2:0]               o_flags,
   output logic [DROP_W-1:0]        o_drop_cnt
);

   logic                     r_valid;
   logic signed [DATA_W-1:0] r_peak;
   logic [WID_W-1:0]         r_width;
   logic [SUM_W-1:0]         r_sum;
   logic [TS_W-1:0]          r_ts;
   logic [2:0]               r_flags;
   logic [DROP_W-1:0]        r_drop;

   logic w_xfer;
   logic w_load;
   logic w_drop;

   assign w_xfer = r_valid & i_ready;
   // A slot being emptied this cycle can take the new event.
   assign w_load = i_emit & (~r_valid | i_ready);
   assign w_drop = i_emit & r_valid & ~i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_peak  <= '0;
         r_width <= '0;
         r_sum   <= '0;
         r_ts    <= '0;
         r_flags <= '0;
         r_drop  <= '0;
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_peak  <= i_peak;
            r_width <= i_width;
            r_sum   <= i_sum;
            r_ts    <= i_ts;
            r_flags <= i_flags;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
         if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_peak     = r_peak;
   assign o_width    = r_width;
   assign o_sum      = r_sum;
   assign o_ts       = r_ts;
   assign o_flags    = r_flags;
   assign o_drop_cnt = r_drop;

endmodule

// File: rtl/pulse_event_detector.sv
// pulse_event_detector: hysteresis pulse finder producing peak/width/sum/ts events.
// Ports: clk, rst (sync, high); s_valid/s_data samples; thr_hi/thr_lo thresholds;
//        ev_valid/ev_ready + ev_peak/width/sum/ts/flags event; busy; drop_cnt.
// Build option: define PULSE_DET_PILEUP_EN to enable pile-up tracking (ev_flags[1]).
// MAX_WIDTH is expected to be at least 2 and below 2**WID_W.
module pulse_event_detector
   import pulse_det_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TS_W      = DEF_TS_W,
   parameter int SUM_W     = DEF_SUM_W,
   parameter int WID_W     = DEF_WID_W,
   parameter int MIN_WIDTH = DEF_MIN_WIDTH,
   parameter int MAX_WIDTH = DEF_MAX_WIDTH,
   parameter int HOLDOFF   = DEF_HOLDOFF
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic signed [DATA_W-1:0] s_data,
   input  logic signed [DATA_W-1:0] thr_hi,
   input  logic signed [DATA_W-1:0] thr_lo,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic signed [DATA_W-1:0] ev_peak,
   output logic [WID_W-1:0]         ev_width,
   output logic [SUM_W-1:0]         ev_sum,
   output logic [TS_W-1:0]          ev_ts,
   output logic [2:0]               ev_flags,
   output logic                     busy,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int ACC_W  = SUM_W + 2;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   state_t                   r_state;
   logic [TS_W-1:0]          r_tscnt;
   logic [TS_W-1:0]          r_ts;
   logic [WID_W-1:0]         r_width;
   logic signed [DATA_W-1:0] r_peak;
   logic [SUM_W-1:0]         r_sum;
   logic                     r_sat;
   logic [HOLD_W-1:0]        r_hold;

   logic signed [DATA_W-1:0] w_lo_eff;
   logic                     w_above_hi;
   logic                     w_above_lo;
   logic [WID_W-1:0]         w_width_inc;
   logic                     w_trunc;
   logic                     w_end;
   logic signed [DATA_W-1:0] w_peak_nx;
   logic signed [ACC_W-1:0]  w_acc;
   logic                     w_acc_ovf;
   logic [SUM_W-1:0]         w_sum_nx;
   logic [SUM_W-1:0]         w_start_sum;
   logic                     w_pile_cur;
   logic                     w_pile_nx;

   logic                     w_emit;
   logic signed [DATA_W-1:0] w_ev_peak;
   logic [WID_W-1:0]         w_ev_width;
   logic [SUM_W-1:0]         w_ev_sum;
   logic [2:0]               w_ev_flags;

   assign w_lo_eff    = (thr_lo < thr_hi) ? thr_lo : thr_hi;
   assign w_above_hi  = s_data > thr_hi;
   assign w_above_lo  = s_data > w_lo_eff;
   assign w_width_inc = r_width + 1'b1;
   assign w_trunc     = w_width_inc == WID_W'(MAX_WIDTH);
   assign w_end       = ~w_above_lo | w_trunc;
   assign w_peak_nx   = (s_data > r_peak) ? s_data : r_peak;

   // Signed add with two guard bits: clamp at 0 below, at all-ones above.
   assign w_acc = $signed({2'b00, r_sum})
                + $signed({{(ACC_W-DATA_W){s_data[DATA_W-1]}}, s_data});
   assign w_acc_ovf = w_acc > $signed({2'b00, {SUM_W{1'b1}}});
   assign w_sum_nx  = w_acc[ACC_W-1] ? '0 :
                      w_acc_ovf      ? '1 : w_acc[SUM_W-1:0];
   assign w_start_sum = s_data[DATA_W-1] ? '0
                      : SUM_W'($unsigned(s_data));

`ifdef PULSE_DET_PILEUP_EN
   logic r_fell;
   logic r_pile;

   // A return above thr_hi after dipping below it marks overlapping pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fell <= 1'b0;
         r_pile <= 1'b0;
      end else if (s_valid) begin
         if (r_state == ST_IDLE) begin
            r_fell <= 1'b0;
            r_pile <= 1'b0;
         end else if (r_state == ST_PULSE && w_above_lo) begin
            if (!w_above_hi) r_fell <= 1'b1;
            r_pile <= w_pile_nx;
         end
      end
   end

   assign w_pile_cur = r_pile;
   assign w_pile_nx  = r_pile | (r_fell & w_above_hi);
`else
   assign w_pile_cur = 1'b0;
   assign w_pile_nx  = 1'b0;
`endif

   // Event contents for the sample that ends the pulse.
   always_comb begin
      w_emit     = 1'b0;
      w_ev_peak  = r_peak;
      w_ev_width = r_width;
      w_ev_sum   = r_sum;
      w_ev_flags = '0;
      w_ev_flags[FLG_PILEUP] = w_pile_cur;
      w_ev_flags[FLG_SUMSAT] = r_sat;
      if (s_valid && r_state == ST_PULSE) begin
         if (!w_above_lo) begin
            w_emit = r_width >= WID_W'(MIN_WIDTH);
         end else if (w_trunc) begin
            w_emit     = 1'b1;
            w_ev_peak  = w_peak_nx;
            w_ev_width = w_width_inc;
            w_ev_sum   = w_sum_nx;
            w_ev_flags[FLG_TRUNC]  = 1'b1;
            w_ev_flags[FLG_PILEUP] = w_pile_nx;
            w_ev_flags[FLG_SUMSAT] = r_sat | w_acc_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tscnt <= '0;
         r_ts    <= '0;
         r_width <= '0;
         r_peak  <= '0;
         r_sum   <= '0;
         r_sat   <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_tscnt <= r_tscnt + 1'b1;
         if (s_valid) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_above_hi) begin
                     r_state <= ST_PULSE;
                     r_width <= WID_W'(1);
                     r_peak  <= s_data;
                     r_sum   <= w_start_sum;
                     r_ts    <= r_tscnt;
                     r_sat   <= 1'b0;
                  end
               end
               ST_PULSE: begin
                  if (w_end) begin
                     r_state <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                     r_hold  <= '0;
                  end else begin
                     r_width <= w_width_inc;
                     r_peak  <= w_peak_nx;
                     r_sum   <= w_sum_nx;
                     r_sat   <= r_sat | w_acc_ovf;
                  end
               end
               ST_HOLDOFF: begin
                  if (r_hold == HOLD_W'(HOLDOFF - 1)) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_hold <= r_hold + 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy = r_state != ST_IDLE;

   pulse_event_slot #(
      .DATA_W (DATA_W),
      .TS_W   (TS_W),
      .SUM_W  (SUM_W),
      .WID_W  (WID_W)
   ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_emit     (w_emit),
      .i_peak     (w_ev_peak),
      .i_width    (w_ev_width),
      .i_sum      (w_ev_sum),
      .i_ts       (r_ts),
      .i_flags    (w_ev_flags),
      .i_ready    (ev_ready),
      .o_valid    (ev_valid),
      .o_peak     (ev_peak),
      .o_width    (ev_width),
      .o_sum      (ev_sum),
      .o_ts       (ev_ts),
      .o_flags    (ev_flags),
      .o_drop_cnt (drop_cnt)
   );

endmodule
